// File: rtl/draw_queue_pkg.sv
// draw_pkg: shared layout constants, command record and issue-state encoding for draw_queue
package draw_pkg;
  localparam logic [7:0] X0 = 8'd4;
  localparam logic [7:0] PITCH = 8'd20;
  localparam logic [6:0] PLAYER_Y = 7'd80;
  localparam logic [6:0] DEALER_Y = 7'd20;
  typedef struct packed {
    logic init;
    logic [5:0] card;
    logic [14:0] orig;
  } draw_cmd_t;
  typedef enum logic [1:0] {IDLE, SETTLE, BUSY} issue_state_t;
  function automatic logic [14:0] slot_orig(input logic hand, input logic [7:0] n);
    logic [7:0] x;
    x = X0 + n * PITCH;
    return {x, hand ? DEALER_Y : PLAYER_Y};
  endfunction
endpackage

// File: rtl/draw_queue_if.sv
// draw_queue_if: request channel from the controller and command channel to print
interface draw_queue_if;
  logic req_valid;
  logic req_ready;
  logic req_init;
  logic req_hand;
  logic [5:0] req_card;
  logic write;
  logic init;
  logic [5:0] card;
  logic [14:0] orig;
  logic waitrequest;
  logic overflow;
  logic pending;
  modport master (
    output req_valid, req_init, req_hand, req_card, waitrequest,
    input  req_ready, write, init, card, orig, overflow, pending
  );
  modport slave (
    input  req_valid, req_init, req_hand, req_card, waitrequest,
    output req_ready, write, init, card, orig, overflow, pending
  );
endinterface

// File: rtl/draw_queue_cmd_fifo.sv
// cmd_fifo: first-word-fall-through command FIFO with wrap-bit pointers
module cmd_fifo import draw_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  draw_cmd_t din,
  output draw_cmd_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  draw_cmd_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  // storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  // pointer advance, guarded so a full push or empty pop is a no-op
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/draw_queue.sv
// draw_queue: lays out card requests per hand, buffers them and replays them into print
module draw_queue import draw_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int MAX_SLOTS = 7
) (
  input logic        clk,
  input logic        rst_n,
  draw_queue_if.slave bus
);
  localparam int SW = $clog2(MAX_SLOTS + 1);
  logic [SW-1:0] cnt_p, cnt_d, n;
  logic full, empty, accept, room, push, pop, overflow, pending;
  draw_cmd_t din, dout, cmd;
  issue_state_t state, nxt;
  assign accept = bus.req_valid && !full;
  assign n = bus.req_hand ? cnt_d : cnt_p;
  assign room = n < SW'(MAX_SLOTS);
  assign push = accept && (bus.req_init || room);
  assign din = bus.req_init ? draw_cmd_t'({1'b1, 6'd0, 15'd0})
                            : draw_cmd_t'({1'b0, bus.req_card, slot_orig(bus.req_hand, 8'(n))});
  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .din(din), .dout(dout), .full(full), .empty(empty)
  );
  // issue decision and next state; SETTLE ignores waitrequest while print raises it
  always_comb begin
    pop = state == IDLE && !empty && !bus.waitrequest;
    nxt = state == IDLE ? (pop ? SETTLE : IDLE)
        : state == SETTLE ? BUSY
        : bus.waitrequest ? BUSY : IDLE;
  end
  // state register plus pending flag derived from current state and occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pending <= 1'b0;
    end else begin
      state <= nxt;
      pending <= !empty || state != IDLE;
    end
  // issued command is held on the outputs until the next pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cmd <= '0;
    else if (pop) cmd <= dout;
  // per-hand slot counters and sticky overflow; init restarts layout
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_p <= '0;
      cnt_d <= '0;
      overflow <= 1'b0;
    end else if (accept && bus.req_init) begin
      cnt_p <= '0;
      cnt_d <= '0;
      overflow <= 1'b0;
    end else if (accept && !room) begin
      overflow <= 1'b1;
    end else if (accept) begin
      if (bus.req_hand) cnt_d <= cnt_d + 1'b1;
      else cnt_p <= cnt_p + 1'b1;
    end
  assign bus.req_ready = !full;
  assign bus.write = state == SETTLE;
  assign bus.init = cmd.init;
  assign bus.card = cmd.card;
  assign bus.orig = cmd.orig;
  assign bus.overflow = overflow;
  assign bus.pending = pending;
endmodule

// File: tb/tb_draw_queue.sv
// tb_draw_queue: directed checks of layout, queuing, issue timing, overflow and reset
module tb_draw_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy = 0;
  int busy_len = 5;
  bit hold = 1'b0;
  logic [21:0] wlog[$];
  int wcyc[$];
  draw_queue_if bus();
  draw_queue #(.DEPTH(8), .MAX_SLOTS(7)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // print model: busy for busy_len cycles after each write, frozen while hold is set
  always @(posedge clk)
    if (bus.write) busy <= busy_len;
    else if (busy > 0 && !hold) busy <= busy - 1;
  assign bus.waitrequest = busy != 0;
  // log every issued command and the cycle it appeared in
  always @(negedge clk)
    if (bus.write) begin
      wlog.push_back({bus.init, bus.card, bus.orig});
      wcyc.push_back(cyc);
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] wat(input int i);
    return wlog.size() > i ? 32'(wlog[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] exp_card(input bit hand, input int slot, input int c);
    logic [7:0] x;
    x = 8'(4 + 20 * slot);
    return 32'({1'b0, 6'(c), x, hand ? 7'd20 : 7'd80});
  endfunction
  task automatic send(input bit ini, input bit hand, input logic [5:0] c, output int acc);
    int w = 0;
    bus.req_valid = 1'b1;
    bus.req_init = ini;
    bus.req_hand = hand;
    bus.req_card = c;
    while (!bus.req_ready && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!bus.req_ready) chk("send_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    bus.req_valid = 1'b0;
  endtask
  task automatic drain();
    int w = 0;
    repeat (2) @(posedge clk);
    #1;
    while ((bus.pending || bus.waitrequest) && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_pending", 32'(bus.pending), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int a0, a, a_first, nw;
    bus.req_valid = 1'b0;
    bus.req_init = 1'b0;
    bus.req_hand = 1'b0;
    bus.req_card = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write", 32'(bus.write), 32'd0);
    chk("rst_init", 32'(bus.init), 32'd0);
    chk("rst_card", 32'(bus.card), 32'd0);
    chk("rst_orig", 32'(bus.orig), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wlog.delete();
    wcyc.delete();
    send(1'b1, 1'b0, 6'd0, a0);
    send(1'b0, 1'b0, 6'd12, a);
    send(1'b0, 1'b0, 6'd33, a);
    drain();
    chk("t1_count", 32'(wlog.size()), 32'd3);
    chk("t1_init", wat(0), 32'h0020_0000);
    chk("t1_card12", wat(1), 32'({1'b0, 6'd12, 15'd592}));
    chk("t1_card33", wat(2), 32'({1'b0, 6'd33, 15'd3152}));
    if (wcyc.size() >= 2) begin
      chk("t1_latency", 32'(wcyc[0] - a0), 32'd1);
      chk("t1_gap", 32'(wcyc[1] - wcyc[0]), 32'd8);
    end
    chk("t1_hold_card", 32'(bus.card), 32'd33);
    chk("t1_hold_orig", 32'(bus.orig), 32'd3152);
    send(1'b0, 1'b1, 6'd5, a);
    drain();
    chk("t2_dealer", wat(3), 32'({1'b0, 6'd5, 15'd532}));
    send(1'b1, 1'b0, 6'd0, a);
    drain();
    wlog.delete();
    wcyc.delete();
    hold = 1'b1;
    send(1'b0, 1'b0, 6'd10, a_first);
    for (int i = 1; i < 9; i++) send(1'b0, i[0], 6'(10 + i), a);
    chk("bp_accept_span", 32'(a - a_first), 32'd8);
    chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
    chk("bp_in_flight", 32'(wlog.size()), 32'd1);
    chk("bp_pending", 32'(bus.pending), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_init = 1'b0;
    bus.req_hand = 1'b0;
    bus.req_card = 6'd63;
    repeat (3) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("bp_still_full", 32'(bus.req_ready), 32'd0);
    hold = 1'b0;
    drain();
    chk("bp_count", 32'(wlog.size()), 32'd9);
    for (int i = 0; i < 9; i++) chk($sformatf("bp_cmd%0d", i), wat(i), exp_card(i[0], i / 2, 10 + i));
    for (int i = 1; i < wcyc.size(); i++) chk($sformatf("bp_gap%0d", i), 32'(wcyc[i] - wcyc[i-1] >= 3), 32'd1);
    busy_len = 0;
    send(1'b1, 1'b0, 6'd0, a);
    drain();
    wlog.delete();
    wcyc.delete();
    for (int i = 0; i < 8; i++) send(1'b0, 1'b0, 6'(i + 1), a);
    drain();
    chk("ov_count", 32'(wlog.size()), 32'd7);
    for (int i = 0; i < 7; i++) chk($sformatf("ov_cmd%0d", i), wat(i), exp_card(1'b0, i, i + 1));
    chk("ov_last_x124", wat(6), 32'({1'b0, 6'd7, 15'd15952}));
    for (int i = 1; i < wcyc.size(); i++) chk($sformatf("ov_rate%0d", i), 32'(wcyc[i] - wcyc[i-1]), 32'd3);
    chk("ov_flag", 32'(bus.overflow), 32'd1);
    send(1'b1, 1'b0, 6'd0, a);
    drain();
    chk("ov_cleared", 32'(bus.overflow), 32'd0);
    busy_len = 5;
    hold = 1'b1;
    wlog.delete();
    wcyc.delete();
    for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 6'(20 + i), a);
    chk("mr_pending", 32'(bus.pending), 32'd1);
    nw = wlog.size();
    chk("mr_one_issued", 32'(nw), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_write", 32'(bus.write), 32'd0);
    chk("mr_pending_rst", 32'(bus.pending), 32'd0);
    chk("mr_ready", 32'(bus.req_ready), 32'd1);
    chk("mr_orig", 32'(bus.orig), 32'd0);
    chk("mr_card", 32'(bus.card), 32'd0);
    repeat (3) @(posedge clk);
    hold = 1'b0;
    #3;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("mr_no_write", 32'(wlog.size()), 32'(nw));
    chk("mr_idle", 32'(bus.pending), 32'd0);
    send(1'b0, 1'b0, 6'd7, a);
    drain();
    chk("mr_slot0", wat(nw), 32'({1'b0, 6'd7, 15'd592}));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
